mm_tile_scheduler: RTL and testbench

//  Command-level sequencer in front of the mm engine. Accepts one matrix-multiply job (N nodes, Ci/Co

---
 rtl/mm_tile_scheduler_if.sv | 37 +++
 rtl/mm_tile_scheduler.sv | 152 +++++++++++++++
 tb/tb_mm_tile_scheduler.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mm_tile_scheduler_if.sv
// Job command channel plus mm engine config/start/done bundle for mm_tile_scheduler.
// master: the scheduler itself; slave: the job source together with the mm engine.
interface mm_tile_scheduler_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [12:0] cmd_weight_addr;
    logic [10:0] cmd_input_addr;
    logic [10:0] cmd_output_addr;
    logic [7:0]  cmd_ci;
    logic [7:0]  cmd_co;
    logic [15:0] cmd_n;

    logic        mm_start_valid;
    logic [12:0] mm_weight_start_addr;
    logic [10:0] mm_input_start_addr;
    logic [10:0] mm_output_start_addr;
    logic [7:0]  mm_input_addr_per_feature;
    logic [7:0]  mm_output_addr_per_feature;
    logic [15:0] mm_number_of_node;
    logic        mm_done;

    modport master (
        input  cmd_valid, cmd_weight_addr, cmd_input_addr, cmd_output_addr,
        input  cmd_ci, cmd_co, cmd_n, mm_done,
        output cmd_ready, mm_start_valid, mm_weight_start_addr, mm_input_start_addr,
        output mm_output_start_addr, mm_input_addr_per_feature, mm_output_addr_per_feature,
        output mm_number_of_node
    );

    modport slave (
        output cmd_valid, cmd_weight_addr, cmd_input_addr, cmd_output_addr,
        output cmd_ci, cmd_co, cmd_n, mm_done,
        input  cmd_ready, mm_start_valid, mm_weight_start_addr, mm_input_start_addr,
        input  mm_output_start_addr, mm_input_addr_per_feature, mm_output_addr_per_feature,
        input  mm_number_of_node
    );
endinterface

// File: rtl/mm_tile_scheduler.sv
// Splits one matrix-multiply job into tiles of at most TILE_N nodes and sequences the mm engine.
// Optional MM_SCHED_PERF_EN adds busy-cycle and tile-count performance counters.
module mm_tile_scheduler #(
    parameter int TILE_N = 64,
    parameter int PERF_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    mm_tile_scheduler_if.master  if_bus,
    output logic                 o_busy,
    output logic                 o_job_done,
`ifdef MM_SCHED_PERF_EN
    output logic                 o_err_cfg,
    output logic [PERF_W-1:0]    o_perf_busy_cycles,
    output logic [15:0]          o_perf_tiles
`else
    output logic                 o_err_cfg
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_ERR, S_ISSUE, S_WAIT, S_ADVANCE, S_DONE
    } state_e;

    localparam logic [15:0] TILE_V = 16'(TILE_N);

    state_e      r_state;
    state_e      w_state_next;
    logic [12:0] r_weight_addr;
    logic [10:0] r_input_addr;
    logic [10:0] r_output_addr;
    logic [7:0]  r_ci;
    logic [7:0]  r_co;
    logic [15:0] r_rem;
    logic [15:0] r_nodes;
    logic        w_accept;
    logic        w_cfg_bad;
    logic [15:0] w_tile;
    logic [15:0] w_rem_next;
    logic [10:0] w_in_step;
    logic [10:0] w_out_step;

    // Node count minus one for the tile that starts with rem nodes left; rem is nonzero.
    function automatic logic [15:0] tile_nodes(input logic [15:0] rem);
        return (rem > TILE_V) ? TILE_V - 16'd1 : rem - 16'd1;
    endfunction

    assign w_accept   = if_bus.cmd_valid && (r_state == S_IDLE);
    assign w_cfg_bad  = (if_bus.cmd_ci == 8'd0) || (if_bus.cmd_co == 8'd0) || (if_bus.cmd_n == 16'd0);
    assign w_tile     = r_nodes + 16'd1;
    assign w_rem_next = r_rem - w_tile;
    // The products are 24 bits wide; only the low 11 survive the modulo-2048 address add.
    assign w_in_step  = 11'(24'(w_tile) * 24'(r_ci));
    assign w_out_step = 11'(24'(w_tile) * 24'(r_co));

    // NOTE: reset is sampled on the clock edge only, so it stays out of the sensitivity list.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next          = r_state;
        if_bus.cmd_ready      = 1'b0;
        if_bus.mm_start_valid = 1'b0;
        o_busy                = 1'b1;
        o_job_done            = 1'b0;
        o_err_cfg             = 1'b0;
        case (r_state)
            S_IDLE: begin
                if_bus.cmd_ready = 1'b1;
                o_busy           = 1'b0;
                if (if_bus.cmd_valid) w_state_next = w_cfg_bad ? S_ERR : S_ISSUE;
            end
            S_ERR: begin
                o_err_cfg    = 1'b1;
                o_job_done   = 1'b1;
                w_state_next = S_IDLE;
            end
            S_ISSUE: begin
                if_bus.mm_start_valid = 1'b1;
                w_state_next          = S_WAIT;
            end
            S_WAIT: begin
                if (if_bus.mm_done) w_state_next = S_ADVANCE;
            end
            S_ADVANCE: begin
                w_state_next = (w_rem_next == 16'd0) ? S_DONE : S_ISSUE;
            end
            S_DONE: begin
                o_job_done   = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // The next tile size is resolved on accept/advance, so config is already valid in ISSUE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_weight_addr <= '0;
            r_input_addr  <= '0;
            r_output_addr <= '0;
            r_ci          <= '0;
            r_co          <= '0;
            r_rem         <= '0;
            r_nodes       <= '0;
        end else if (w_accept) begin
            r_weight_addr <= if_bus.cmd_weight_addr;
            r_input_addr  <= if_bus.cmd_input_addr;
            r_output_addr <= if_bus.cmd_output_addr;
            r_ci          <= if_bus.cmd_ci;
            r_co          <= if_bus.cmd_co;
            r_rem         <= if_bus.cmd_n;
            r_nodes       <= (if_bus.cmd_n == 16'd0) ? 16'd0 : tile_nodes(if_bus.cmd_n);
        end else if (r_state == S_ADVANCE) begin
            r_rem         <= w_rem_next;
            r_input_addr  <= r_input_addr + w_in_step;
            r_output_addr <= r_output_addr + w_out_step;
            if (w_rem_next != 16'd0) r_nodes <= tile_nodes(w_rem_next);
        end
    end

    assign if_bus.mm_weight_start_addr       = r_weight_addr;
    assign if_bus.mm_input_start_addr        = r_input_addr;
    assign if_bus.mm_output_start_addr       = r_output_addr;
    assign if_bus.mm_input_addr_per_feature  = r_ci;
    assign if_bus.mm_output_addr_per_feature = r_co;
    assign if_bus.mm_number_of_node          = r_nodes;

`ifdef MM_SCHED_PERF_EN
    logic [PERF_W-1:0] r_perf_busy_cycles;
    logic [15:0]       r_perf_tiles;

    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_perf_busy_cycles <= '0;
            r_perf_tiles       <= '0;
        end else begin
            if (o_busy && (r_perf_busy_cycles != '1)) r_perf_busy_cycles <= r_perf_busy_cycles + 1'b1;
            if ((r_state == S_ISSUE) && (r_perf_tiles != '1)) r_perf_tiles <= r_perf_tiles + 16'd1;
        end
    end

    assign o_perf_busy_cycles = r_perf_busy_cycles;
    assign o_perf_tiles       = r_perf_tiles;
`else
    localparam int unused_perf_w = PERF_W;
`endif

endmodule

// File: tb/tb_mm_tile_scheduler.sv
// Self-checking bench for mm_tile_scheduler: job table, tile scoreboard, and hand-written
// sequences for reset, stray mm_done and held-off commands.
module tb_mm_tile_scheduler;

    localparam int TILE_N = 64;

    typedef struct {
        logic [12:0] w;
        logic [10:0] in_a;
        logic [10:0] out_a;
        logic [7:0]  ci;
        logic [7:0]  co;
        logic [15:0] n;
        int          exp_starts;
        logic [15:0] exp_last_nodes;
        logic [10:0] exp_last_in;
        logic [10:0] exp_last_out;
    } vec_t;

    typedef struct {
        logic [15:0] nodes;
        logic [10:0] in_a;
        logic [10:0] out_a;
    } start_t;

    logic clk = 1'b0;
    logic rst;
    logic w_busy;
    logic w_job_done;
    logic w_err_cfg;
`ifdef MM_SCHED_PERF_EN
    logic [31:0] w_perf_busy_cycles;
    logic [15:0] w_perf_tiles;
`endif

    vec_t   vecs[9];
    start_t sb[$];
    int     n_vec  = 0;
    int     n_fail = 0;

    mm_tile_scheduler_if bus ();

    mm_tile_scheduler #(.TILE_N(TILE_N), .PERF_W(32)) dut (
        .clk                (clk),
        .rst                (rst),
        .if_bus             (bus),
        .o_busy             (w_busy),
        .o_job_done         (w_job_done),
`ifdef MM_SCHED_PERF_EN
        .o_err_cfg          (w_err_cfg),
        .o_perf_busy_cycles (w_perf_busy_cycles),
        .o_perf_tiles       (w_perf_tiles)
`else
        .o_err_cfg          (w_err_cfg)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference tiling of one legal job into the expected sequence of mm starts.
    task automatic model_push(input vec_t v);
        logic [15:0] rem;
        logic [15:0] t;
        logic [10:0] ia;
        logic [10:0] oa;
        start_t      s;
        rem = v.n;
        ia  = v.in_a;
        oa  = v.out_a;
        while (rem != 16'd0) begin
            t       = (rem > 16'(TILE_N)) ? 16'(TILE_N) : rem;
            s.nodes = t - 16'd1;
            s.in_a  = ia;
            s.out_a = oa;
            sb.push_back(s);
            ia  = ia + 11'(32'(t) * 32'(v.ci));
            oa  = oa + 11'(32'(t) * 32'(v.co));
            rem = rem - t;
        end
    endtask

    task automatic drive_cmd(input vec_t v);
        bus.cmd_weight_addr = v.w;
        bus.cmd_input_addr  = v.in_a;
        bus.cmd_output_addr = v.out_a;
        bus.cmd_ci          = v.ci;
        bus.cmd_co          = v.co;
        bus.cmd_n           = v.n;
        bus.cmd_valid       = 1'b1;
    endtask

    task automatic scramble_cmd();
        bus.cmd_weight_addr = 13'($urandom);
        bus.cmd_input_addr  = 11'($urandom);
        bus.cmd_output_addr = 11'($urandom);
        bus.cmd_ci          = 8'($urandom);
        bus.cmd_co          = 8'($urandom);
        bus.cmd_n           = 16'($urandom);
    endtask

    task automatic run_job(input vec_t v);
        start_t      exp_s;
        logic [15:0] hold_nodes;
        logic [21:0] hold_addr;
        int          starts;
        bit          err;
        starts = 0;
        err    = (v.ci == 8'd0) || (v.co == 8'd0) || (v.n == 16'd0);
        if (!err) model_push(v);
        check("ready_before_job", bus.cmd_ready, 1);
        drive_cmd(v);
        tick();
        bus.cmd_valid = 1'b0;
        scramble_cmd();
        if (err) begin
            check("err_cfg_pulse", w_err_cfg, 1);
            check("err_job_done", w_job_done, 1);
            check("err_no_start", bus.mm_start_valid, 0);
            tick();
            check("err_cfg_clear", w_err_cfg, 0);
            check("err_ready_after", bus.cmd_ready, 1);
            check("err_start_after", bus.mm_start_valid, 0);
            return;
        end
        for (int k = 0; k < v.exp_starts + 2; k++) begin
            check("start_pulse", bus.mm_start_valid, 1);
            starts++;
            exp_s = (sb.size() != 0) ? sb.pop_front() : '{nodes: '0, in_a: '0, out_a: '0};
            check("tile_nodes", bus.mm_number_of_node, exp_s.nodes);
            check("tile_in_addr", bus.mm_input_start_addr, exp_s.in_a);
            check("tile_out_addr", bus.mm_output_start_addr, exp_s.out_a);
            check("tile_w_addr", bus.mm_weight_start_addr, v.w);
            check("tile_ci_co", {bus.mm_input_addr_per_feature, bus.mm_output_addr_per_feature},
                  {v.ci, v.co});
            if (starts == v.exp_starts) begin
                check("last_nodes", bus.mm_number_of_node, v.exp_last_nodes);
                check("last_in_addr", bus.mm_input_start_addr, v.exp_last_in);
                check("last_out_addr", bus.mm_output_start_addr, v.exp_last_out);
            end
            hold_nodes = bus.mm_number_of_node;
            hold_addr  = {bus.mm_input_start_addr, bus.mm_output_start_addr};
            bus.mm_done = 1'b1;  // lands in the ISSUE cycle and must be ignored
            tick();
            bus.mm_done = 1'b0;
            for (int c = 0; c < 1 + (starts % 3); c++) begin
                bus.cmd_valid = (c == 0);
                check("wait_no_start", bus.mm_start_valid, 0);
                check("wait_busy", w_busy, 1);
                check("wait_ready", bus.cmd_ready, 0);
                check("wait_nodes_hold", bus.mm_number_of_node, hold_nodes);
                check("wait_addr_hold", {bus.mm_input_start_addr, bus.mm_output_start_addr}, hold_addr);
                tick();
            end
            bus.cmd_valid = 1'b0;
            bus.mm_done   = 1'b1;
            tick();
            bus.mm_done = 1'b0;
            check("adv_no_start", bus.mm_start_valid, 0);
            check("adv_no_done", w_job_done, 0);
            check("adv_busy", w_busy, 1);
            tick();
            check("job_done_timing", w_job_done, (starts == v.exp_starts));
            if (w_job_done) begin
                check("done_no_err", w_err_cfg, 0);
                tick();
                check("done_clear", w_job_done, 0);
                check("done_ready", bus.cmd_ready, 1);
                check("done_idle", w_busy, 0);
                break;
            end
        end
        check("start_count", starts, v.exp_starts);
        check("sb_leftover", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          w        in       out      ci     co     n        st last_n  last_in  last_out
        vecs[0] = '{13'h040, 11'h010, 11'h100, 8'd2,  8'd3,  16'd100, 2, 16'd35, 11'h090, 11'h1C0};
        vecs[1] = '{13'h1FFF, 11'h000, 11'h7FF, 8'd4, 8'd5,  16'd64,  1, 16'd63, 11'h000, 11'h7FF};
        vecs[2] = '{13'h011, 11'h020, 11'h030, 8'd0,  8'd3,  16'd10,  0, 16'd0,  11'h000, 11'h000};
        vecs[3] = '{13'h002, 11'h7F0, 11'h000, 8'd1,  8'd1,  16'd80,  2, 16'd15, 11'h030, 11'h040};
        vecs[4] = '{13'h003, 11'h001, 11'h002, 8'd5,  8'd0,  16'd10,  0, 16'd0,  11'h000, 11'h000};
        vecs[5] = '{13'h004, 11'h003, 11'h004, 8'd5,  8'd6,  16'd0,   0, 16'd0,  11'h000, 11'h000};
        vecs[6] = '{13'h0AA, 11'h123, 11'h456, 8'd255, 8'd255, 16'd1, 1, 16'd0,  11'h123, 11'h456};
        vecs[7] = '{13'h155, 11'h000, 11'h000, 8'd7,  8'd1,  16'd200, 4, 16'd7,  11'h540, 11'h0C0};
        vecs[8] = '{13'h0FF, 11'h400, 11'h001, 8'd255, 8'd128, 16'd65, 2, 16'd0,  11'h3C0, 11'h001};

        rst         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.mm_done   = 1'b0;
        scramble_cmd();
        repeat (3) tick();
        check("rst_ready", bus.cmd_ready, 1);
        check("rst_busy", w_busy, 0);
        check("rst_start", bus.mm_start_valid, 0);
        check("rst_flags", {w_job_done, w_err_cfg}, 0);
        check("rst_cfg_nodes", bus.mm_number_of_node, 0);
        check("rst_cfg_addr", {bus.mm_weight_start_addr, bus.mm_input_start_addr}, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            run_job(vecs[i]);
            tick();
        end

        // Stray mm_done while idle changes nothing.
        bus.mm_done = 1'b1;
        tick();
        bus.mm_done = 1'b0;
        check("idle_done_ready", bus.cmd_ready, 1);
        check("idle_done_busy", w_busy, 0);
        check("idle_done_start", bus.mm_start_valid, 0);
        check("idle_done_jobdone", w_job_done, 0);

        // Reset while waiting on mm: everything returns to reset values, late mm_done ignored.
        drive_cmd(vecs[0]);
        tick();
        bus.cmd_valid = 1'b0;
        check("rstw_start", bus.mm_start_valid, 1);
        tick();
        check("rstw_in_wait", w_busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstw_busy", w_busy, 0);
        check("rstw_ready", bus.cmd_ready, 1);
        check("rstw_nodes", bus.mm_number_of_node, 0);
        check("rstw_addr", {bus.mm_weight_start_addr, bus.mm_input_start_addr, bus.mm_output_start_addr}, 0);
        check("rstw_ci_co", {bus.mm_input_addr_per_feature, bus.mm_output_addr_per_feature}, 0);
        check("rstw_jobdone", w_job_done, 0);
        bus.mm_done = 1'b1;
        tick();
        bus.mm_done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("rstw_late_done", {w_busy, w_job_done, bus.mm_start_valid}, 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
